// File: rtl/bit_serializer_if.sv
// Load handshake and serial-output bundle for bit_serializer.
// master = word producer / serial consumer side, slave = the serializer itself.
interface bit_serializer_if #(
  parameter int unsigned WIDTH = 8
);
  logic [WIDTH-1:0] load_data;
  logic             load_valid;
  logic             load_ready;
  logic             ser_out;
  logic             ser_valid;
  logic             frame_done;

  modport master (
    output load_data,
    output load_valid,
    input  load_ready,
    input  ser_out,
    input  ser_valid,
    input  frame_done
  );

  modport slave (
    input  load_data,
    input  load_valid,
    output load_ready,
    output ser_out,
    output ser_valid,
    output frame_done
  );
endinterface

// File: rtl/bit_serializer.sv
// Parallel-to-serial front end: accepts a WIDTH-bit word over valid/ready and
// shifts it out one bit per clock. The line idles high between frames, with an
// optional GAP of idle-high cycles after each frame. All outputs are registered.
module bit_serializer #(
  parameter int unsigned WIDTH     = 8,
  parameter bit          MSB_FIRST = 1'b1,
  parameter int unsigned GAP       = 2
) (
  input logic             clk,
  input logic             rst,
  bit_serializer_if.slave bus
);

  localparam int unsigned CntW      = $clog2(WIDTH);
  localparam logic [CntW-1:0] LastCnt   = CntW'(WIDTH - 1);
  localparam logic [CntW-1:0] PenultCnt = CntW'(WIDTH - 2);
  // Unreachable when GAP == 0; kept in range so the compare stays well-formed.
  localparam logic [3:0] GapLast = (GAP == 0) ? 4'd0 : 4'(GAP - 1);

  typedef enum logic [1:0] {StIdle, StShift, StGap} state_e;

  state_e          state_q, state_d;
  logic [WIDTH-1:0] shreg_q, shreg_d;
  logic [CntW-1:0] bit_cnt_q, bit_cnt_d;
  logic [3:0]      gap_cnt_q, gap_cnt_d;
  logic            ser_out_q, ser_out_d;
  logic            ser_valid_q, ser_valid_d;
  logic            frame_done_q, frame_done_d;
  logic            load_ready_q, load_ready_d;
  logic            accept;

  // Bit that leaves the word first, given the configured bit order.
  function automatic logic out_bit(input logic [WIDTH-1:0] w);
    return MSB_FIRST ? w[WIDTH-1] : w[0];
  endfunction

  // Shift toward the output end; vacated positions fill with 1 (idle level).
  function automatic logic [WIDTH-1:0] shift_word(input logic [WIDTH-1:0] w);
    return MSB_FIRST ? {w[WIDTH-2:0], 1'b1} : {1'b1, w[WIDTH-1:1]};
  endfunction

  assign accept = bus.load_valid & load_ready_q;

  // State and registered outputs; reset leaves the line idle high and ready.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= StIdle;
      shreg_q      <= '0;
      bit_cnt_q    <= '0;
      gap_cnt_q    <= '0;
      ser_out_q    <= 1'b1;
      ser_valid_q  <= 1'b0;
      frame_done_q <= 1'b0;
      load_ready_q <= 1'b1;
    end else begin
      state_q      <= state_d;
      shreg_q      <= shreg_d;
      bit_cnt_q    <= bit_cnt_d;
      gap_cnt_q    <= gap_cnt_d;
      ser_out_q    <= ser_out_d;
      ser_valid_q  <= ser_valid_d;
      frame_done_q <= frame_done_d;
      load_ready_q <= load_ready_d;
    end
  end

  // Next-state and next-output logic; outputs default to the idle-high line.
  always_comb begin
    state_d      = state_q;
    shreg_d      = shreg_q;
    bit_cnt_d    = bit_cnt_q;
    gap_cnt_d    = gap_cnt_q;
    ser_out_d    = 1'b1;
    ser_valid_d  = 1'b0;
    frame_done_d = 1'b0;
    load_ready_d = load_ready_q;

    unique case (state_q)
      StIdle: begin
        load_ready_d = 1'b1;
        if (accept) begin
          state_d      = StShift;
          ser_out_d    = out_bit(bus.load_data);
          shreg_d      = shift_word(bus.load_data);
          ser_valid_d  = 1'b1;
          bit_cnt_d    = '0;
          load_ready_d = 1'b0;
        end
      end

      StShift: begin
        if (bit_cnt_q == LastCnt) begin
          if (GAP > 0) begin
            state_d      = StGap;
            gap_cnt_d    = '0;
            load_ready_d = 1'b0;
          end else if (accept) begin
            // Back-to-back: first bit of the next word follows immediately.
            ser_out_d    = out_bit(bus.load_data);
            shreg_d      = shift_word(bus.load_data);
            ser_valid_d  = 1'b1;
            bit_cnt_d    = '0;
            load_ready_d = 1'b0;
          end else begin
            state_d      = StIdle;
            load_ready_d = 1'b1;
          end
        end else begin
          ser_out_d    = out_bit(shreg_q);
          shreg_d      = shift_word(shreg_q);
          ser_valid_d  = 1'b1;
          bit_cnt_d    = bit_cnt_q + 1'b1;
          frame_done_d = (bit_cnt_q == PenultCnt);
          // With no gap, a new word may be taken during the last-bit cycle.
          load_ready_d = (bit_cnt_q == PenultCnt) && (GAP == 0);
        end
      end

      StGap: begin
        load_ready_d = 1'b0;
        if (gap_cnt_q == GapLast) begin
          state_d      = StIdle;
          gap_cnt_d    = '0;
          load_ready_d = 1'b1;
        end else begin
          gap_cnt_d = gap_cnt_q + 1'b1;
        end
      end

      default: begin
        state_d      = StIdle;
        load_ready_d = 1'b1;
      end
    endcase
  end

  assign bus.ser_out    = ser_out_q;
  assign bus.ser_valid  = ser_valid_q;
  assign bus.frame_done = frame_done_q;
  assign bus.load_ready = load_ready_q;

endmodule
